// File: rtl/scc_mem_dump_tx_pkg.sv
// Shared definitions for the memory dump writer: state codes, ASCII
// strings, LINE byte layout and hex formatting helpers.
package scc_mem_dump_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_RD_REQ  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_LINE    = 3'd4;
  localparam logic [2:0] ST_CSUM    = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int HDR_LEN  = 14;
  localparam int LINE_LEN = 22;
  localparam int CSUM_LEN = 16;
  localparam int CSUM_PFX_LEN = 7;

  localparam logic [8*HDR_LEN-1:0] HDR_STR = "Address,Value\n";
  localparam logic [8*CSUM_PFX_LEN-1:0] CSUM_PFX = "CSUM,0x";

  // LINE layout: "0x" AAAAAAAA ",0x" VVVVVVVV "\n"
  localparam int LN_ADDR0 = 2;
  localparam int LN_SEP   = 10;
  localparam int LN_VAL0  = 13;
  localparam int LN_NL    = 21;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // k selects the digit, most significant nibble first
  function automatic logic [7:0] hex_digit(
    input logic [31:0] w,
    input logic [2:0]  k
  );
    logic [31:0] s;
    s = w << {k, 2'b00};
    return hex_ascii(s[31:28]);
  endfunction

  function automatic logic [7:0] str_byte(
    input logic [127:0] s,
    input int           len,
    input logic [4:0]   idx
  );
    logic [127:0] t;
    t = s >> (8 * (len - 1 - int'(idx)));
    return t[7:0];
  endfunction

endpackage

// File: rtl/scc_dump_line_fmt.sv
// Combinational formatter for one CSV dump line:
// {addr, value, byte_idx} -> ASCII byte.
module scc_dump_line_fmt
  import scc_mem_dump_tx_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       value,
  input  logic [4:0]        byte_idx,
  output logic [7:0]        tx_byte
);

  logic [31:0] addr32;
  logic [4:0]  a_k;
  logic [4:0]  v_k;

  assign addr32 = 32'(addr);
  assign a_k    = byte_idx - 5'(LN_ADDR0);
  assign v_k    = byte_idx - 5'(LN_VAL0);

  always_comb begin
    tx_byte = 8'h0a;
    unique case (1'b1)
      (byte_idx == 5'd0),
      (byte_idx == 5'(LN_SEP + 1)):
        tx_byte = "0";
      (byte_idx == 5'd1),
      (byte_idx == 5'(LN_SEP + 2)):
        tx_byte = "x";
      (byte_idx >= 5'(LN_ADDR0) && byte_idx < 5'(LN_SEP)):
        tx_byte = hex_digit(addr32, a_k[2:0]);
      (byte_idx == 5'(LN_SEP)):
        tx_byte = ",";
      (byte_idx >= 5'(LN_VAL0) && byte_idx < 5'(LN_NL)):
        tx_byte = hex_digit(value, v_k[2:0]);
      default:
        tx_byte = 8'h0a;
    endcase
  end

endmodule

// File: rtl/scc_mem_dump_tx.sv
// Halt-triggered "Address,Value" CSV memory dump over a byte valid/ready port.
// Define SCC_DUMP_CSUM_EN to append a "CSUM,0x........" trailer line.
module scc_mem_dump_tx
  import scc_mem_dump_tx_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_f,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              dump_done
);

`ifdef SCC_DUMP_CSUM_EN
  localparam logic [2:0] ST_TAIL = ST_CSUM;
`else
  localparam logic [2:0] ST_TAIL = ST_DONE;
`endif
  localparam bit EMPTY = (START_ADDR > END_ADDR);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       value;
  logic [4:0]        byte_idx;
  logic [7:0]        line_byte;
  logic              acc;

  assign acc       = tx_valid && tx_ready;
  assign mem_rd_en = (state == ST_RD_REQ);
  assign mem_addr  = addr;
  assign tx_valid  = (state == ST_HDR) || (state == ST_LINE) ||
                     (state == ST_CSUM);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);

`ifdef SCC_DUMP_CSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 32'hFFFF_FFFF;
    end else if (state == ST_IDLE) begin
      csum <= 32'hFFFF_FFFF;
    end else if (state == ST_RD_WAIT) begin
      csum <= csum ^ mem_rd_data ^
              ((mem_rd_data >> 3) & (mem_rd_data << 5));
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= START_ADDR;
      value     <= 32'h0;
      byte_idx  <= 5'd0;
      dump_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (halt_f && !dump_done) begin
            state    <= ST_HDR;
            addr     <= START_ADDR;
            byte_idx <= 5'd0;
          end
        end
        ST_HDR: begin
          if (acc) begin
            if (byte_idx == 5'(HDR_LEN - 1)) begin
              byte_idx <= 5'd0;
              if (EMPTY) begin
                state <= ST_TAIL;
                if (ST_TAIL == ST_DONE) dump_done <= 1'b1;
              end else begin
                state <= ST_RD_REQ;
              end
            end else begin
              byte_idx <= byte_idx + 5'd1;
            end
          end
        end
        ST_RD_REQ: state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          value    <= mem_rd_data;
          byte_idx <= 5'd0;
          state    <= ST_LINE;
        end
        ST_LINE: begin
          if (acc) begin
            if (byte_idx == 5'(LINE_LEN - 1)) begin
              byte_idx <= 5'd0;
              // compare before increment so END_ADDR at the top never wraps
              if (addr == END_ADDR) begin
                state <= ST_TAIL;
                if (ST_TAIL == ST_DONE) dump_done <= 1'b1;
              end else begin
                addr  <= addr + ADDR_W'(4);
                state <= ST_RD_REQ;
              end
            end else begin
              byte_idx <= byte_idx + 5'd1;
            end
          end
        end
`ifdef SCC_DUMP_CSUM_EN
        ST_CSUM: begin
          if (acc) begin
            if (byte_idx == 5'(CSUM_LEN - 1)) begin
              state     <= ST_DONE;
              dump_done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 5'd1;
            end
          end
        end
`endif
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  scc_dump_line_fmt #(
    .ADDR_W   (ADDR_W)
  ) u_line_fmt (
    .addr     (addr),
    .value    (value),
    .byte_idx (byte_idx),
    .tx_byte  (line_byte)
  );

  always_comb begin
    tx_data = 8'h00;
    unique case (1'b1)
      (state == ST_HDR):
        tx_data = str_byte(128'(HDR_STR), HDR_LEN, byte_idx);
      (state == ST_LINE):
        tx_data = line_byte;
`ifdef SCC_DUMP_CSUM_EN
      (state == ST_CSUM): begin
        if (byte_idx < 5'(CSUM_PFX_LEN))
          tx_data = str_byte(128'(CSUM_PFX), CSUM_PFX_LEN, byte_idx);
        else if (byte_idx < 5'(CSUM_LEN - 1))
          tx_data = hex_digit(csum, 3'(byte_idx - 5'(CSUM_PFX_LEN)));
        else
          tx_data = 8'h0a;
      end
`endif
      default:
        tx_data = 8'h00;
    endcase
  end

endmodule
